// File: rtl/net_frame_fifo_if.sv
// Bundle for the 64b/66b block FIFO: write side, read side and status.
// The FIFO connects through the slave modport; the PHY/scheduler side uses master.
interface net_frame_fifo_if #(
  parameter int DWIDTH = 64,
  parameter int CWIDTH = 2,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [DWIDTH-1:0] wr_data;
  logic [CWIDTH-1:0] wr_ctrl;
  logic              rd_en;
  logic [DWIDTH-1:0] rd_data;
  logic [CWIDTH-1:0] rd_ctrl;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [AW:0]       space;
  logic [AW:0]       frame_cnt;
  logic              netfin;
  logic              overflow;

  // wr_en/rd_en are requests sampled at the rising edge; a request is taken
  // only when full/empty (as registered at the start of that cycle) allow it.
  // rd_valid marks the single cycle after an accepted read.
  modport master (
    output wr_en, wr_data, wr_ctrl, rd_en,
    input  rd_data, rd_ctrl, rd_valid, empty, full, space, frame_cnt, netfin, overflow
  );

  modport slave (
    input  wr_en, wr_data, wr_ctrl, rd_en,
    output rd_data, rd_ctrl, rd_valid, empty, full, space, frame_cnt, netfin, overflow
  );
endinterface

// File: rtl/net_frame_fifo.sv
// 64b/66b block FIFO with optional IDLE drop, complete-frame count, read-side
// frame boundary flag and exact free-space report.
module net_frame_fifo #(
  parameter int DWIDTH    = 64,
  parameter int CWIDTH    = 2,
  parameter int DEPTH     = 16,
  parameter bit DROP_IDLE = 1'b1
) (
  input logic             clk,
  input logic             reset,
  net_frame_fifo_if.slave bus
);
  localparam int              AW        = $clog2(DEPTH);
  localparam int              WW        = CWIDTH + DWIDTH;
  localparam logic [CWIDTH-1:0] SYNC_CTRL = CWIDTH'(1);
  localparam logic [AW:0]     DEPTH_W   = (AW+1)'(DEPTH);

  logic [WW-1:0]     mem [DEPTH];

  logic [AW:0]       wp_q, rp_q;
  logic [AW:0]       wp_nxt, rp_nxt, occ_nxt;
  logic [AW:0]       space_q, frame_cnt_q, frame_cnt_nxt;
  logic              empty_q, full_q, netfin_q, overflow_q, rd_valid_q;
  logic [DWIDTH-1:0] rd_data_q;
  logic [CWIDTH-1:0] rd_ctrl_q;

  logic [WW-1:0]     rd_word;
  logic              wr_is_idle, wr_is_term, rd_is_term;
  logic              wr_acc, rd_acc;
  logic              wr_term_acc, rd_term_acc;

  assign rd_word = mem[rp_q[AW-1:0]];

  assign wr_is_idle = (bus.wr_ctrl == SYNC_CTRL) && (bus.wr_data[7:0] == 8'h1E);
  assign wr_is_term = (bus.wr_ctrl == SYNC_CTRL) && (bus.wr_data[7:0] > 8'h86);
  assign rd_is_term = (rd_word[WW-1 -: CWIDTH] == SYNC_CTRL) && (rd_word[7:0] > 8'h86);

  // Both accepts look only at the registered flags, so a same-cycle read never
  // frees room for a write and a same-cycle write never bypasses to the read.
  assign wr_acc = bus.wr_en && !full_q && !(DROP_IDLE && wr_is_idle);
  assign rd_acc = bus.rd_en && !empty_q;

  assign wr_term_acc = wr_acc && wr_is_term;
  assign rd_term_acc = rd_acc && rd_is_term;

  always_comb begin
    wp_nxt        = wp_q + (AW+1)'(wr_acc);
    rp_nxt        = rp_q + (AW+1)'(rd_acc);
    occ_nxt       = wp_nxt - rp_nxt;
    frame_cnt_nxt = frame_cnt_q;
    if (wr_term_acc && !rd_term_acc) begin
      frame_cnt_nxt = frame_cnt_q + 1'b1;
    end else if (!wr_term_acc && rd_term_acc) begin
      frame_cnt_nxt = frame_cnt_q - 1'b1;
    end
  end

  // Storage carries no reset; entries behind the read pointer are don't-care.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp_q[AW-1:0]] <= {bus.wr_ctrl, bus.wr_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q        <= '0;
      rp_q        <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      space_q     <= DEPTH_W;
      frame_cnt_q <= '0;
      netfin_q    <= 1'b1;
      overflow_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_ctrl_q   <= '0;
    end else begin
      wp_q        <= wp_nxt;
      rp_q        <= rp_nxt;
      empty_q     <= (wp_nxt == rp_nxt);
      full_q      <= (wp_nxt[AW-1:0] == rp_nxt[AW-1:0]) && (wp_nxt[AW] != rp_nxt[AW]);
      space_q     <= DEPTH_W - occ_nxt;
      frame_cnt_q <= frame_cnt_nxt;
      rd_valid_q  <= rd_acc;
      if (bus.wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
      if (rd_acc) begin
        rd_data_q <= rd_word[DWIDTH-1:0];
        rd_ctrl_q <= rd_word[WW-1 -: CWIDTH];
        netfin_q  <= rd_is_term;
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_ctrl   = rd_ctrl_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.space     = space_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.netfin    = netfin_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_net_frame_fifo.sv
// Directed + random bench for net_frame_fifo: scoreboard queue of written
// blocks, status model checked after every clock.
module tb_net_frame_fifo;
  localparam int DW    = 64;
  localparam int CW    = 2;
  localparam int DEPTH = 16;
  localparam int WW    = CW + DW;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [CW-1:0] wr_ctrl = '0;
  logic          rd_en = 1'b0;

  net_frame_fifo_if #(.DWIDTH(DW), .CWIDTH(CW), .DEPTH(DEPTH)) bus ();
  net_frame_fifo_if #(.DWIDTH(DW), .CWIDTH(CW), .DEPTH(DEPTH)) bus0 ();

  assign bus.wr_en    = wr_en;
  assign bus.wr_data  = wr_data;
  assign bus.wr_ctrl  = wr_ctrl;
  assign bus.rd_en    = rd_en;
  assign bus0.wr_en   = wr_en;
  assign bus0.wr_data = wr_data;
  assign bus0.wr_ctrl = wr_ctrl;
  assign bus0.rd_en   = rd_en;

  net_frame_fifo #(.DWIDTH(DW), .CWIDTH(CW), .DEPTH(DEPTH), .DROP_IDLE(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  net_frame_fifo #(.DWIDTH(DW), .CWIDTH(CW), .DEPTH(DEPTH), .DROP_IDLE(1'b0)) dut_keep (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] exp_q[$];
  int            m_occ;
  int            m_frames;
  bit            m_netfin;
  bit            m_ovf;
  logic [WW-1:0] m_last;
  int            n_vec  = 0;
  int            n_miss = 0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_term(input logic [WW-1:0] w);
    return (w[WW-1:DW] == 2'b01) && (w[7:0] > 8'h86);
  endfunction

  function automatic bit is_idle(input logic [WW-1:0] w);
    return (w[WW-1:DW] == 2'b01) && (w[7:0] == 8'h1E);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_occ    = 0;
    m_frames = 0;
    m_netfin = 1'b1;
    m_ovf    = 1'b0;
    m_last   = '0;
  endtask

  // Called mid-cycle: outputs must take reset values without waiting for an edge.
  task automatic apply_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_empty",    WW'(bus.empty),     WW'(1));
    chk("rst_full",     WW'(bus.full),      WW'(0));
    chk("rst_space",    WW'(bus.space),     WW'(DEPTH));
    chk("rst_frames",   WW'(bus.frame_cnt), WW'(0));
    chk("rst_netfin",   WW'(bus.netfin),    WW'(1));
    chk("rst_overflow", WW'(bus.overflow),  WW'(0));
    chk("rst_rd_valid", WW'(bus.rd_valid),  WW'(0));
    chk("rst_rd_word",  {bus.rd_ctrl, bus.rd_data}, WW'(0));
    model_clear();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic step(input bit we, input logic [CW-1:0] wc, input logic [DW-1:0] wd, input bit re);
    logic [WW-1:0] w;
    logic [WW-1:0] head;
    bit            wacc;
    bit            racc;
    w    = {wc, wd};
    wacc = we && (m_occ < DEPTH) && !is_idle(w);
    racc = re && (m_occ > 0);
    wr_en   = we;
    wr_ctrl = wc;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
    if (we && (m_occ == DEPTH)) m_ovf = 1'b1;
    if (racc) begin
      head     = exp_q.pop_front();
      m_last   = head;
      m_netfin = is_term(head);
      if (is_term(head)) m_frames--;
      m_occ--;
    end
    if (wacc) begin
      exp_q.push_back(w);
      if (is_term(w)) m_frames++;
      m_occ++;
    end
    chk("rd_valid",  WW'(bus.rd_valid),  WW'(racc));
    chk("rd_word",   {bus.rd_ctrl, bus.rd_data}, m_last);
    chk("empty",     WW'(bus.empty),     WW'(m_occ == 0));
    chk("full",      WW'(bus.full),      WW'(m_occ == DEPTH));
    chk("space",     WW'(bus.space),     WW'(DEPTH - m_occ));
    chk("frame_cnt", WW'(bus.frame_cnt), WW'(m_frames));
    chk("netfin",    WW'(bus.netfin),    WW'(m_netfin));
    chk("overflow",  WW'(bus.overflow),  WW'(m_ovf));
  endtask

  task automatic drain();
    while (m_occ > 0) step(1'b0, 2'b10, '0, 1'b1);
    step(1'b0, 2'b10, '0, 1'b0);
  endtask

  initial begin
    logic [7:0]    lo;
    logic [DW-1:0] pay;
    model_clear();
    apply_reset();

    // T1: fill to full, then one refused write
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'b10, DW'(i), 1'b0);
    step(1'b1, 2'b10, 64'hDEAD, 1'b0);

    // T2: read everything back in order
    for (int i = 0; i < DEPTH; i++) step(1'b0, 2'b10, '0, 1'b1);
    step(1'b0, 2'b10, '0, 1'b0);

    // T3: one complete frame, start / 3 data / terminate
    step(1'b1, 2'b01, 64'h0000_0000_0000_0078, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 64'h1111_0000_0000_0000 + DW'(i), 1'b0);
    step(1'b1, 2'b01, 64'h0000_0000_0000_0087, 1'b0);
    chk("t3_frames", WW'(bus.frame_cnt), WW'(1));
    drain();
    chk("t3_netfin", WW'(bus.netfin), WW'(1));

    // T4: idle blocks dropped on dut, kept on dut_keep
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 64'h0000_0000_0000_001E, 1'b0);
    chk("t4_keep_space", WW'(bus0.space), WW'(11));
    chk("t4_keep_empty", WW'(bus0.empty), WW'(0));

    // T5: sustained read+write at occupancy 3, pointers wrap twice
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10, DW'(32'hA000 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      pay = {$urandom, $urandom};
      step(1'b1, 2'b10, pay, 1'b1);
    end
    chk("t5_space", WW'(bus.space), WW'(DEPTH - 3));
    drain();

    // Read+write when full: write refused; when empty: read refused
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'b10, DW'(32'hB000 + i), 1'b0);
    step(1'b1, 2'b10, 64'hBAD, 1'b1);
    drain();
    step(1'b1, 2'b01, 64'h0000_0000_0000_0090, 1'b1);
    drain();

    // Random mix of data, terminate, idle and start blocks
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       lo = 8'h1E;
        1:       lo = 8'(32'($urandom_range(8'h87, 8'hFF)));
        2:       lo = 8'h78;
        default: lo = 8'($urandom);
      endcase
      pay = {$urandom, $urandom};
      pay[7:0] = lo;
      step($urandom_range(0, 1) == 1, ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, pay,
           $urandom_range(0, 2) != 0);
    end
    drain();

    // T6: reset mid-burst at occupancy 7, then a fresh write/read
    for (int i = 0; i < 7; i++) step(1'b1, 2'b10, DW'(32'hC000 + i), 1'b0);
    apply_reset();
    step(1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0);
    step(1'b0, 2'b10, '0, 1'b1);
    chk("t6_readback", {bus.rd_ctrl, bus.rd_data}, {2'b10, 64'h0123_4567_89AB_CDEF});
    step(1'b0, 2'b10, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
